instr_fetch: RTL

Fetch stage directly upstream of the instruction decoder. Holds the program counter and reads instruction words from a synchronous-read instruction memory. Latches each word into an instruction register and presents opcode and operand fields to the decoder. Uses the decoder's pc_en to advance the PC or halt (STOP / illegal opcode).

---
 rtl/instr_fetch.sv | 80 ++++++++
 1 files changed

// File: rtl/instr_fetch.sv
// instr_fetch: PC/IR fetch stage feeding the decoder (FETCH -> WAIT -> EXEC per instruction).
// Define FETCH_STEP_EN to add the step input and a PAUSE state for single-stepping.
module instr_fetch #(
    parameter int ADDR_W  = 5,
    parameter int OPC_W   = 3,
    parameter int INSTR_W = OPC_W + ADDR_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
`ifdef FETCH_STEP_EN
    input  logic               step,
`endif
    output logic               imem_rd,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [OPC_W-1:0]   opcode,
    output logic [ADDR_W-1:0]  operand,
    output logic               instr_valid,
    input  logic               pc_en,
    output logic [ADDR_W-1:0]  pc,
    output logic               halted
);
    typedef enum logic [2:0] {
        IDLE, FETCH, WAIT, EXEC, HALT
`ifdef FETCH_STEP_EN
        , PAUSE
`endif
    } state_t;

`ifdef FETCH_STEP_EN
    localparam state_t ADVANCE = PAUSE;
`else
    localparam state_t ADVANCE = FETCH;
`endif

    state_t             state, state_d;
    logic [INSTR_W-1:0] ir;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    state_d = start ? FETCH : IDLE;
            FETCH:   state_d = WAIT;
            WAIT:    state_d = EXEC;
            EXEC:    state_d = pc_en ? ADVANCE : HALT;
            HALT:    state_d = start ? FETCH : HALT;
`ifdef FETCH_STEP_EN
            PAUSE:   state_d = step ? FETCH : PAUSE;
`endif
            default: state_d = IDLE;
        endcase
    end

    // Read data arrives during WAIT; a reset in WAIT drops it before it reaches IR.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= '0;
            ir <= '0;
        end else begin
            if (state == WAIT) ir <= imem_data;
            if (state == EXEC && pc_en) pc <= pc + ADDR_W'(1);
            else if ((state == IDLE || state == HALT) && start) pc <= '0;
        end
    end

    always_comb begin
        imem_rd     = state == FETCH;
        instr_valid = state == EXEC;
        halted      = state == HALT;
        imem_addr   = pc;
        opcode      = ir[INSTR_W-1 -: OPC_W];
        operand     = ir[ADDR_W-1:0];
    end
endmodule
